// File: rtl/rsa_pkg.sv
// Shared sizes, state encoding and operand payload for the RSA exponentiation sequencer.
package rsa_pkg;

    localparam int unsigned BITS  = 256;
    localparam int unsigned GUARD = 14;
    localparam int unsigned MP_W  = BITS + GUARD;
    localparam int unsigned CNT_W = $clog2(BITS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MONT_GO,
        S_MONT_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [BITS-1:0] a;
        logic [BITS-1:0] d;
        logic [BITS-1:0] n;
    } operands_t;

endpackage

// File: rtl/rsa_exp_ctrl.sv
// Sequencer for o = a^d mod n: one ModProd pre-scale, then BITS lock-step
// Montgomery multiply/square iterations scanning the exponent LSB first.
module rsa_exp_ctrl
    import rsa_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_d,
    input  logic [BITS-1:0] i_n,
    output logic [BITS-1:0] o_a_pow_d,
    output logic            o_finished,
    output logic            o_mp_start,
    output logic [MP_W-1:0] o_mp_a,
    input  logic [MP_W-1:0] i_mp_a,
    input  logic            i_mp_end,
    output logic            o_mont_start,
    output logic [BITS-1:0] o_mont_m_a,
    output logic [BITS-1:0] o_mont_m_b,
    output logic [BITS-1:0] o_mont_t_a,
    input  logic [BITS-1:0] i_mont_m_res,
    input  logic [BITS-1:0] i_mont_t_res,
    input  logic            i_mont_m_end,
    input  logic            i_mont_t_end
);

    state_t          state, state_nxt;
    operands_t       ops_r, ops_nxt;
    logic [BITS-1:0] m_r, m_nxt;
    logic [BITS-1:0] t_r, t_nxt;
    logic [BITS-1:0] m_res_r, m_res_nxt;
    logic [BITS-1:0] t_res_r, t_res_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic            m_done, m_done_nxt;
    logic            t_done, t_done_nxt;
    logic [BITS-1:0] result_nxt;
    logic            mp_start_nxt;
    logic            mont_start_nxt;
    logic            finished_nxt;

    // Modulus is held for the datapath configuration; the guard bits of the ModProd result are never needed.
    logic            unused_bits;
    assign unused_bits = ^{ops_r.n, i_mp_a[MP_W-1:BITS]};

    // Operands to the external units come straight from the working registers.
    assign o_mp_a     = {{GUARD{1'b0}}, ops_r.a};
    assign o_mont_m_a = m_r;
    assign o_mont_m_b = t_r;
    assign o_mont_t_a = t_r;

    // Next-state, next-data and next-output logic.
    always_comb begin
        state_nxt      = state;
        ops_nxt        = ops_r;
        m_nxt          = m_r;
        t_nxt          = t_r;
        m_res_nxt      = m_res_r;
        t_res_nxt      = t_res_r;
        cnt_nxt        = cnt_r;
        m_done_nxt     = m_done;
        t_done_nxt     = t_done;
        result_nxt     = o_a_pow_d;
        mp_start_nxt   = 1'b0;
        mont_start_nxt = 1'b0;
        finished_nxt   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    ops_nxt      = '{a: i_a, d: i_d, n: i_n};
                    mp_start_nxt = 1'b1;
                    state_nxt    = S_PREP;
                end
            end
            S_PREP: begin
                if (i_mp_end) begin
                    t_nxt          = i_mp_a[BITS-1:0];
                    m_nxt          = BITS'(1);
                    cnt_nxt        = '0;
                    mont_start_nxt = 1'b1;
                    state_nxt      = S_MONT_GO;
                end
            end
            S_MONT_GO: begin
                m_done_nxt = 1'b0;
                t_done_nxt = 1'b0;
                state_nxt  = S_MONT_WAIT;
            end
            S_MONT_WAIT: begin
                // Sticky flags: first end pulse of each unit wins, order is free.
                if (i_mont_m_end && !m_done) begin
                    m_done_nxt = 1'b1;
                    m_res_nxt  = i_mont_m_res;
                end
                if (i_mont_t_end && !t_done) begin
                    t_done_nxt = 1'b1;
                    t_res_nxt  = i_mont_t_res;
                end
                if (m_done_nxt && t_done_nxt) begin
                    state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (ops_r.d[cnt_r[CNT_W-2:0]]) begin
                    m_nxt = m_res_r;
                end
                t_nxt = t_res_r;
                // Fixed iteration count keeps the run time independent of the exponent.
                if (cnt_r == CNT_W'(BITS - 1)) begin
                    result_nxt   = m_nxt;
                    finished_nxt = 1'b1;
                    state_nxt    = S_DONE;
                end else begin
                    cnt_nxt        = cnt_r + CNT_W'(1);
                    mont_start_nxt = 1'b1;
                    state_nxt      = S_MONT_GO;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, data and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            ops_r        <= '0;
            m_r          <= '0;
            t_r          <= '0;
            m_res_r      <= '0;
            t_res_r      <= '0;
            cnt_r        <= '0;
            m_done       <= 1'b0;
            t_done       <= 1'b0;
            o_a_pow_d    <= '0;
            o_finished   <= 1'b0;
            o_mp_start   <= 1'b0;
            o_mont_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            ops_r        <= ops_nxt;
            m_r          <= m_nxt;
            t_r          <= t_nxt;
            m_res_r      <= m_res_nxt;
            t_res_r      <= t_res_nxt;
            cnt_r        <= cnt_nxt;
            m_done       <= m_done_nxt;
            t_done       <= t_done_nxt;
            o_a_pow_d    <= result_nxt;
            o_finished   <= finished_nxt;
            o_mp_start   <= mp_start_nxt;
            o_mont_start <= mont_start_nxt;
        end
    end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Bench for rsa_exp_ctrl: behavioural ModProd/Montgomery units with programmable
// latencies, an independent modpow reference and a result/latency scoreboard.
module tb_rsa_exp_ctrl;
    import rsa_pkg::*;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_start;
    logic [BITS-1:0] i_a, i_d, i_n;
    logic [BITS-1:0] o_a_pow_d;
    logic            o_finished;
    logic            o_mp_start;
    logic [MP_W-1:0] o_mp_a;
    logic [MP_W-1:0] i_mp_a;
    logic            i_mp_end;
    logic            o_mont_start;
    logic [BITS-1:0] o_mont_m_a, o_mont_m_b, o_mont_t_a;
    logic [BITS-1:0] i_mont_m_res, i_mont_t_res;
    logic            i_mont_m_end, i_mont_t_end;

    rsa_exp_ctrl dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_a          (i_a),
        .i_d          (i_d),
        .i_n          (i_n),
        .o_a_pow_d    (o_a_pow_d),
        .o_finished   (o_finished),
        .o_mp_start   (o_mp_start),
        .o_mp_a       (o_mp_a),
        .i_mp_a       (i_mp_a),
        .i_mp_end     (i_mp_end),
        .o_mont_start (o_mont_start),
        .o_mont_m_a   (o_mont_m_a),
        .o_mont_m_b   (o_mont_m_b),
        .o_mont_t_a   (o_mont_t_a),
        .i_mont_m_res (i_mont_m_res),
        .i_mont_t_res (i_mont_t_res),
        .i_mont_m_end (i_mont_m_end),
        .i_mont_t_end (i_mont_t_end)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int mont_cnt = 0;
    int unsigned lat_mp = 1, lat_m = 1, lat_t = 1;
    logic [BITS-1:0] cur_a = '0, cur_n = 1;
    logic prev_mp = 1'b0, prev_mont = 1'b0;
    logic [BITS-1:0] exp_q[$];
    int lat_q[$];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    task automatic check(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // x*y mod n by shift-and-add, MSB first (x < n).
    function automatic logic [BITS-1:0] mulmod(input logic [BITS-1:0] x, input logic [BITS-1:0] y,
                                               input logic [BITS-1:0] n);
        logic [BITS+1:0] r = '0;
        logic [BITS+1:0] nn = {2'b00, n};
        for (int i = BITS - 1; i >= 0; i--) begin
            r = r << 1;
            if (r >= nn) r = r - nn;
            if (y[i]) begin
                r = r + {2'b00, x};
                if (r >= nn) r = r - nn;
            end
        end
        return r[BITS-1:0];
    endfunction

    // Reference: left-to-right square-and-multiply.
    function automatic logic [BITS-1:0] modpow(input logic [BITS-1:0] a, input logic [BITS-1:0] d,
                                               input logic [BITS-1:0] n);
        logic [BITS-1:0] r = BITS'(1);
        for (int i = BITS - 1; i >= 0; i--) begin
            r = mulmod(r, r, n);
            if (d[i]) r = mulmod(r, a, n);
        end
        return r;
    endfunction

    // x*y*2^-BITS mod n, bit-serial Montgomery reduction.
    function automatic logic [BITS-1:0] mont(input logic [BITS-1:0] x, input logic [BITS-1:0] y,
                                             input logic [BITS-1:0] n);
        logic [BITS+1:0] u = '0;
        for (int i = 0; i < BITS; i++) begin
            if (x[i]) u = u + {2'b00, y};
            if (u[0]) u = u + {2'b00, n};
            u = u >> 1;
        end
        if (u >= {2'b00, n}) u = u - {2'b00, n};
        return u[BITS-1:0];
    endfunction

    // a*2^BITS mod n by repeated doubling.
    function automatic logic [BITS-1:0] prescale(input logic [BITS-1:0] a, input logic [BITS-1:0] n);
        logic [BITS:0] x = {1'b0, a};
        for (int i = 0; i < BITS; i++) begin
            x = x << 1;
            if (x >= {1'b0, n}) x = x - {1'b0, n};
        end
        return x[BITS-1:0];
    endfunction

    function automatic logic [BITS-1:0] rand256();
        logic [BITS-1:0] r;
        for (int i = 0; i < BITS / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ModProd unit model: end pulse lat_mp cycles after its start cycle.
    initial begin
        logic [BITS-1:0] res;
        i_mp_end = 1'b0;
        i_mp_a   = '0;
        forever begin
            @(negedge i_clk);
            if (o_mp_start) begin
                res = prescale(o_mp_a[BITS-1:0], cur_n);
                repeat (lat_mp) @(posedge i_clk);
                #1 i_mp_end = 1'b1;
                i_mp_a = {{GUARD{1'b0}}, res};
                @(posedge i_clk);
                #1 i_mp_end = 1'b0;
                i_mp_a = {{GUARD{1'b1}}, ~res};
            end
        end
    end

    // Montgomery multiply unit model.
    initial begin
        logic [BITS-1:0] res;
        i_mont_m_end = 1'b0;
        i_mont_m_res = '0;
        forever begin
            @(negedge i_clk);
            if (o_mont_start) begin
                res = mont(o_mont_m_a, o_mont_m_b, cur_n);
                repeat (lat_m) @(posedge i_clk);
                #1 i_mont_m_end = 1'b1;
                i_mont_m_res = res;
                @(posedge i_clk);
                #1 i_mont_m_end = 1'b0;
                i_mont_m_res = ~res;
            end
        end
    end

    // Montgomery square unit model.
    initial begin
        logic [BITS-1:0] res;
        i_mont_t_end = 1'b0;
        i_mont_t_res = '0;
        forever begin
            @(negedge i_clk);
            if (o_mont_start) begin
                res = mont(o_mont_t_a, o_mont_t_a, cur_n);
                repeat (lat_t) @(posedge i_clk);
                #1 i_mont_t_end = 1'b1;
                i_mont_t_res = res;
                @(posedge i_clk);
                #1 i_mont_t_end = 1'b0;
                i_mont_t_res = ~res;
            end
        end
    end

    // Output monitor: pulse widths, ModProd operand, and scoreboard pop on o_finished.
    always @(negedge i_clk) begin
        if (o_mont_start) begin
            mont_cnt++;
            check("mont_start_width", BITS'(prev_mont), '0);
        end
        if (o_mp_start) begin
            check("mp_start_width", BITS'(prev_mp), '0);
            check("mp_a", o_mp_a[BITS-1:0], cur_a);
            check("mp_a_guard", BITS'(o_mp_a[MP_W-1:BITS]), '0);
        end
        prev_mont = o_mont_start;
        prev_mp   = o_mp_start;
        if (o_finished) begin
            if (exp_q.size() == 0) begin
                check("spurious_finish", BITS'(o_finished), '0);
            end else begin
                logic [BITS-1:0] e;
                int l;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("result", o_a_pow_d, e);
                check("latency", BITS'(cyc - start_cyc), BITS'(l));
            end
        end
    end

    // One exponentiation with chosen unit latencies; optional ignored start mid-run.
    task automatic run_op(input logic [BITS-1:0] a, input logic [BITS-1:0] d, input logic [BITS-1:0] n,
                          input int unsigned lmp, input int unsigned lm, input int unsigned lt,
                          input bit inject);
        int l;
        int t;
        lat_mp = lmp;
        lat_m  = lm;
        lat_t  = lt;
        l = 2 + int'(lmp) + int'(BITS) * (int'((lm > lt) ? lm : lt) + 2);
        @(negedge i_clk);
        cur_a = a;
        cur_n = n;
        mont_cnt = 0;
        i_a = a;
        i_d = d;
        i_n = n;
        i_start = 1'b1;
        start_cyc = cyc;
        exp_q.push_back(modpow(a, d, n));
        lat_q.push_back(l);
        @(negedge i_clk);
        i_start = 1'b0;
        if (inject) begin
            t = 0;
            while (mont_cnt < 3 && t < 1000) begin
                @(negedge i_clk);
                t++;
            end
            i_a = a ^ BITS'(2);
            i_d = ~d;
            i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
        end
        t = 0;
        while (exp_q.size() != 0 && t < l + 100) begin
            @(negedge i_clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("timeout", BITS'(exp_q.size()), '0);
            exp_q.delete();
            lat_q.delete();
        end
        repeat (4) @(negedge i_clk);
    endtask

    initial begin
        logic [BITS-1:0] ra, rd, rn;
        int t;
        int pulses;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_a = '0;
        i_d = '0;
        i_n = BITS'(1);
        repeat (3) @(negedge i_clk);
        check("rst_result", o_a_pow_d, '0);
        check("rst_finished", BITS'(o_finished), '0);
        check("rst_mp_start", BITS'(o_mp_start), '0);
        check("rst_mont_start", BITS'(o_mont_start), '0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Small known case, then the result must stay held.
        run_op(BITS'(5), BITS'(3), BITS'(23), 2, 2, 2, 1'b0);
        check("result_held", o_a_pow_d, BITS'(10));

        // Zero exponent and (n-1)^2.
        run_op(BITS'(7), BITS'(0), BITS'(11), 1, 1, 1, 1'b0);
        run_op(BITS'(1000002), BITS'(2), BITS'(1000003), 3, 1, 1, 1'b0);

        // Skewed and simultaneous unit completion.
        rn = rand256();
        rn[BITS-1] = 1'b1;
        rn[0] = 1'b1;
        ra = rand256() % rn;
        rd = rand256();
        run_op(ra, rd, rn, 2, 3, 9, 1'b0);
        run_op(ra, rd, rn, 2, 9, 3, 1'b0);
        run_op(ra, rd, rn, 2, 5, 5, 1'b0);

        // Start request during the loop is ignored.
        run_op(BITS'(12345), BITS'(65537), BITS'(99991), 2, 4, 4, 1'b1);

        // Mid-operation reset with unit end pulses still in flight.
        lat_mp = 2;
        lat_m  = 6;
        lat_t  = 8;
        @(negedge i_clk);
        cur_a = BITS'(3);
        cur_n = BITS'(1009);
        mont_cnt = 0;
        i_a = BITS'(3);
        i_d = '1;
        i_n = BITS'(1009);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        t = 0;
        while (mont_cnt < 100 && t < 2000) begin
            @(negedge i_clk);
            t++;
        end
        check("reach_iter_100", BITS'(mont_cnt >= 100), BITS'(1));
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        check("mid_rst_result", o_a_pow_d, '0);
        check("mid_rst_finished", BITS'(o_finished), '0);
        check("mid_rst_mp_start", BITS'(o_mp_start), '0);
        check("mid_rst_mont_start", BITS'(o_mont_start), '0);
        pulses = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_finished || o_mont_start || o_mp_start) pulses++;
        end
        check("post_rst_quiet", BITS'(pulses), '0);
        run_op(BITS'(3), BITS'(200), BITS'(1009), 2, 2, 3, 1'b0);

        // Random operands against the reference.
        for (int k = 0; k < 40; k++) begin
            rn = rand256();
            rn[BITS-1] = 1'b1;
            rn[0] = 1'b1;
            ra = rand256() % rn;
            rd = rand256();
            run_op(ra, rd, rn, $urandom_range(5, 1), $urandom_range(3, 1), $urandom_range(3, 1), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
